// File: rtl/pht_update_scheduler.sv
// PHT write-port controller: table initialisation after reset, then
// arbitration between queued resolution updates and droppable
// speculative updates, each applied as a forwarded read-modify-write.
//
// Handshake: a resolution is transferred on a rising edge where
// i_Res_valid && o_Res_ready; the requester holds its fields stable while
// waiting. Speculative requests have no ready and are either serviced the
// cycle they are presented (queue empty) or dropped and counted.
module pht_update_scheduler #(
  parameter int GHR_SIZE    = 8,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Res_valid,
  input  logic [GHR_SIZE-1:0] i_Res_index,
  input  logic                i_Res_taken,
  input  logic                i_Res_mispredict,
  output logic                o_Res_ready,
  input  logic                i_Spec_valid,
  input  logic [GHR_SIZE-1:0] i_Spec_index,
  input  logic                i_Spec_taken,
  output logic [GHR_SIZE-1:0] o_Pht_rd_addr,
  input  logic [1:0]          i_Pht_rd_data,
  output logic                o_Pht_wr_en,
  output logic [GHR_SIZE-1:0] o_Pht_wr_addr,
  output logic [1:0]          o_Pht_wr_data,
  output logic                o_Fetch_stall,
  output logic [15:0]         o_Drop_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Current FSM state, kept as a plainly named signal for probing.
  state_t              state;
  logic [GHR_SIZE-1:0] init_cnt;

  logic [GHR_SIZE-1:0] q_index [QUEUE_DEPTH];
  logic                q_taken [QUEUE_DEPTH];
  logic                q_mis   [QUEUE_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic                q_empty;
  logic                q_full;
  logic                in_run;
  logic                push;
  logic                pop;
  logic                drop;

  logic                sel_valid;
  logic                sel_is_init;
  logic [GHR_SIZE-1:0] sel_index;
  logic                sel_taken;
  logic                sel_mis;
  logic [1:0]          old_val;
  logic [2:0]          step;
  logic [2:0]          sum;
  logic [1:0]          new_val;

  assign q_empty       = (count == '0);
  assign q_full        = (count == CW'(QUEUE_DEPTH));
  assign in_run        = (state == ST_RUN);
  assign o_Fetch_stall = !in_run;
  assign o_Res_ready   = in_run && !q_full;
  assign push          = i_Res_valid && o_Res_ready;

  // Pick at most one writer: init sweep, else queue head, else speculation.
  always_comb begin
    sel_valid   = 1'b0;
    sel_is_init = 1'b0;
    sel_index   = '0;
    sel_taken   = 1'b0;
    sel_mis     = 1'b0;
    pop         = 1'b0;
    drop        = 1'b0;
    if (!in_run) begin
      sel_valid   = 1'b1;
      sel_is_init = 1'b1;
      sel_index   = init_cnt;
    end else if (!q_empty) begin
      sel_valid = 1'b1;
      sel_index = q_index[rd_ptr];
      sel_taken = q_taken[rd_ptr];
      sel_mis   = q_mis[rd_ptr];
      pop       = 1'b1;
      drop      = i_Spec_valid;
    end else if (i_Spec_valid) begin
      sel_valid = 1'b1;
      sel_index = i_Spec_index;
      sel_taken = i_Spec_taken;
    end
  end

  assign o_Pht_rd_addr = sel_index;

  // Saturating counter update; the in-flight write is forwarded so that
  // back-to-back updates to one index compound instead of reading stale data.
  always_comb begin
    old_val = (o_Pht_wr_en && (o_Pht_wr_addr == sel_index)) ? o_Pht_wr_data
                                                             : i_Pht_rd_data;
    step    = sel_mis ? 3'd2 : 3'd1;
    sum     = {1'b0, old_val} + step;
    if (sel_is_init) begin
      new_val = 2'b10;
    end else if (sel_taken) begin
      new_val = (sum > 3'd3) ? 2'd3 : sum[1:0];
    end else begin
      new_val = ({1'b0, old_val} < step) ? 2'd0 : 2'(({1'b0, old_val} - step));
    end
  end

  // FSM: sweep every index with weakly-taken, then run.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == '1) state <= ST_RUN;
    end
  end

  // Resolution queue storage; contents need no reset, pointers guard them.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      q_index[wr_ptr] <= i_Res_index;
      q_taken[wr_ptr] <= i_Res_taken;
      q_mis[wr_ptr]   <= i_Res_mispredict;
    end
  end

  // Resolution queue pointers and occupancy.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered PHT write port.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Pht_wr_en   <= 1'b0;
      o_Pht_wr_addr <= '0;
      o_Pht_wr_data <= '0;
    end else begin
      o_Pht_wr_en <= sel_valid;
      if (sel_valid) begin
        o_Pht_wr_addr <= sel_index;
        o_Pht_wr_data <= new_val;
      end
    end
  end

  // Saturating count of speculative requests lost to queued resolutions.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Drop_count <= '0;
    end else if (drop && (o_Drop_count != 16'hFFFF)) begin
      o_Drop_count <= o_Drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Bench for pht_update_scheduler: a behavioural PHT memory, a scoreboard of
// expected {addr, data} writes and directed plus randomised scenarios.
module tb_pht_update_scheduler;

  localparam int G = 8;
  localparam int N = 1 << G;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         res_valid = 1'b0;
  logic [G-1:0] res_index = '0;
  logic         res_taken = 1'b0;
  logic         res_mis = 1'b0;
  logic         res_ready;
  logic         spec_valid = 1'b0;
  logic [G-1:0] spec_index = '0;
  logic         spec_taken = 1'b0;
  logic [G-1:0] rd_addr;
  logic [1:0]   rd_data;
  logic         wr_en;
  logic [G-1:0] wr_addr;
  logic [1:0]   wr_data;
  logic         fetch_stall;
  logic [15:0]  drop_count;

  logic [1:0]   mem    [N];
  logic [1:0]   shadow [N];
  logic         stuck = 1'b0;

  logic [G+1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           exp_drops = 0;

  pht_update_scheduler #(.GHR_SIZE(G), .QUEUE_DEPTH(4)) dut (
    .i_Clk           (clk),
    .i_Reset         (rst),
    .i_Res_valid     (res_valid),
    .i_Res_index     (res_index),
    .i_Res_taken     (res_taken),
    .i_Res_mispredict(res_mis),
    .o_Res_ready     (res_ready),
    .i_Spec_valid    (spec_valid),
    .i_Spec_index    (spec_index),
    .i_Spec_taken    (spec_taken),
    .o_Pht_rd_addr   (rd_addr),
    .i_Pht_rd_data   (rd_data),
    .o_Pht_wr_en     (wr_en),
    .o_Pht_wr_addr   (wr_addr),
    .o_Pht_wr_data   (wr_data),
    .o_Fetch_stall   (fetch_stall),
    .o_Drop_count    (drop_count)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  // PHT storage model: asynchronous read, optional stuck read value.
  assign rd_data = stuck ? 2'd2 : mem[rd_addr];

  always @(posedge clk) begin
    if (wr_en === 1'b1) mem[wr_addr] <= wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every observed write must match the head of exp_q.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'(wr_en), 32'd0);
      end else begin
        check("wr", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [1:0] upd(input logic [1:0] old, input logic t, input logic m);
    int s;
    int v;
    s = m ? 2 : 1;
    v = int'(old);
    if (t) return (v + s > 3) ? 2'd3 : 2'(v + s);
    return (v < s) ? 2'd0 : 2'(v - s);
  endfunction

  task automatic exp_upd(input logic [G-1:0] idx, input logic t, input logic m);
    logic [1:0] n;
    n = upd(shadow[idx], t, m);
    shadow[idx] = n;
    exp_q.push_back({idx, n});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one cycle of requests, sampled on the next rising edge.
  task automatic drive(input logic rv, input logic [G-1:0] ri, input logic rt, input logic rm,
                       input logic sv, input logic [G-1:0] si, input logic st);
    res_valid  = rv;
    res_index  = ri;
    res_taken  = rt;
    res_mis    = rm;
    spec_valid = sv;
    spec_index = si;
    spec_taken = st;
    @(posedge clk);
    #1;
    res_valid  = 1'b0;
    spec_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  // Hold reset, check reset outputs, release and follow the init sweep.
  task automatic reset_and_init();
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_stall", 32'(fetch_stall), 32'd1);
    check("rst_ready", 32'(res_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_drops = 0;
    for (int k = 0; k < N; k++) begin
      exp_q.push_back({k[G-1:0], 2'b10});
      shadow[k] = 2'b10;
    end
    for (int k = 0; k < N; k++) begin
      res_valid  = 1'($urandom_range(0, 1));
      res_index  = G'($urandom_range(0, N - 1));
      spec_valid = 1'($urandom_range(0, 1));
      spec_index = G'($urandom_range(0, N - 1));
      @(negedge clk);
      if (k == 0) begin
        check("post_rst_wr_en", 32'(wr_en), 32'd0);
        check("post_rst_drop", 32'(drop_count), 32'd0);
      end
      check("init_stall", 32'(fetch_stall), 32'd1);
      check("init_ready", 32'(res_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    res_valid  = 1'b0;
    spec_valid = 1'b0;
    @(negedge clk);
    check("run_stall", 32'(fetch_stall), 32'd0);
    check("run_ready", 32'(res_ready), 32'd1);
    check("init_drop", 32'(drop_count), 32'd0);
    wait_drain();
  endtask

  initial begin
    // Init sequence.
    reset_and_init();

    // Saturation and forwarding through consecutive speculative updates.
    for (int i = 0; i < 3; i++) begin
      exp_upd(8'h05, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1);
      if (i == 0) check("spec_lat", 32'(wr_en), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      exp_upd(8'h05, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0);
    end
    wait_drain();

    // Mispredicted resolutions, including resolution latency.
    mem[8'h10] = 2'd3;
    shadow[8'h10] = 2'd3;
    exp_upd(8'h10, 1'b0, 1'b1);
    drive(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("res_lat_early", 32'(wr_en), 32'd0);
    idle(1);
    check("res_lat_en", 32'(wr_en), 32'd1);
    check("res_lat_addr", 32'(wr_addr), 32'h10);
    wait_drain();
    exp_upd(8'h10, 1'b0, 1'b1);
    drive(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    wait_drain();
    mem[8'h11] = 2'd0;
    shadow[8'h11] = 2'd0;
    exp_upd(8'h11, 1'b1, 1'b1);
    drive(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    exp_upd(8'h11, 1'b1, 1'b1);
    drive(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    wait_drain();

    // Arbitration: speculation dropped while resolutions are queued.
    for (int i = 0; i < 4; i++) begin
      logic t;
      logic m;
      t = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      check("arb_ready", 32'(res_ready), 32'd1);
      exp_upd(8'h20 + 8'(i), t, m);
      drive(1'b1, 8'h20 + 8'(i), t, m, (i > 0), 8'($urandom_range(128, 255)),
            1'($urandom_range(0, 1)));
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'($urandom_range(128, 255)), 1'b1);
    exp_drops += 4;
    wait_drain();
    check("drop_count", 32'(drop_count), 32'(exp_drops));

    // Forwarding with the PHT read stuck at 2.
    stuck = 1'b1;
    shadow[8'h7F] = 2'd2;
    exp_upd(8'h7F, 1'b1, 1'b0);
    drive(1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    exp_upd(8'h7F, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b1);
    wait_drain();
    shadow[8'h7F] = 2'd2;
    exp_upd(8'h7F, 1'b0, 1'b0);
    drive(1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    exp_upd(8'h7F, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0);
    wait_drain();
    stuck = 1'b0;
    idle(2);
    shadow[8'h7F] = mem[8'h7F];

    // Random resolution stream over a few colliding indices.
    for (int i = 0; i < 16; i++) begin
      logic         v;
      logic [G-1:0] ix;
      logic         t;
      logic         m;
      v  = 1'($urandom_range(0, 1));
      ix = 8'h40 + 8'($urandom_range(0, 3));
      t  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      if (v) exp_upd(ix, t, m);
      drive(v, ix, t, m, 1'b0, '0, 1'b0);
    end
    wait_drain();
    check("drop_before_rst", 32'(drop_count), 32'(exp_drops));

    // Mid-run reset: the third resolution must never be written.
    exp_upd(8'h30, 1'b1, 1'b0);
    drive(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    exp_upd(8'h31, 1'b1, 1'b1);
    drive(1'b1, 8'h31, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 8'h32, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_drop", 32'(drop_count), 32'd0);
    check("midrst_stall", 32'(fetch_stall), 32'd1);
    check("midrst_ready", 32'(res_ready), 32'd0);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    reset_and_init();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
